ram_master: RTL and testbench
=============================

# ram_master

Initiator for the on-chip word-addressed RAM port (en / 4-bit byte write-select / address / write data / registered read data). Accepts one byte, half-word or word load/store at a time from the pipeline's memory stage. Performs alignment checking, byte-lane steering and sign/zero extension. Sequences the RAM's two-cycle write and one-cycle-latency read, and returns a one-cycle response.

## Interface
- `kAddrWidth`, 32, byte address width
- `kDataWidth`, 32, data width; fixed at 4 byte lanes
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted this cycle when both high
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 reserved
- `req_signed`  in  1  sign-extend loads (ignored for word/stores)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle response pulse
- `resp_err`  out  1  misaligned/reserved request, valid with `resp_valid`
- `resp_rdata`  out  32  extended load data, valid with `resp_valid`; 0 for stores/errors
- `ram_en`  out  1  RAM enable
- `ram_write_sel`  out  4  byte-lane write enables, bit k = data[8k+7:8k]
- `ram_addr`  out  32  word-aligned address (bits [1:0] always 0)
- `ram_wdata`  out  32  lane-steered store data
- `ram_rdata`  in  32  RAM registered read data

## Operation
- States: IDLE, READ, RDATA, WRITE, WHOLD, RESP.
- IDLE: `req_ready`=1. On handshake, latch all request fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size 3) → RESP with err, no RAM access.
  - Otherwise load → READ, store → WRITE.
- READ: `ram_en`=1, `ram_write_sel`=0, `ram_addr`={addr[31:2],2'b00} → RDATA.
- RDATA: `ram_en`=0. Capture `ram_rdata` at the end of the cycle: shift right by 8·addr[1:0], then zero/sign-extend per size/signed into `resp_rdata` → RESP.
- WRITE: `ram_en`=1, `ram_write_sel`/`ram_addr`/`ram_wdata` driven → WHOLD.
- WHOLD: `ram_en`=0; `ram_write_sel`, `ram_addr` and `ram_wdata` held unchanged (RAM commits on its internally delayed enable) → RESP.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE. There is no response backpressure.
- Lane steering: byte offset o → sel 1<<o, wdata = byte replicated ×4. Half offset 0 → 0011, offset 2 → 1100, wdata = half replicated ×2. Word → 1111.
- Outside READ/WRITE/WHOLD: `ram_en`=0, `ram_write_sel`=0, `ram_addr`=0, `ram_wdata`=0.
- Out-of-range addresses are not checked; RAM returns 0.

## Timing
- Reset (rst=0): state IDLE. `req_ready`=0 while reset is held. `resp_valid`, `resp_err`, `resp_rdata`, `ram_en`, `ram_write_sel`, `ram_addr`, `ram_wdata` all 0.
- Aligned load or store: handshake at edge 0 → `resp_valid` high in the 3rd cycle after (READ/WRITE, RDATA/WHOLD, RESP).
- Error: `resp_valid` high in the cycle immediately after the handshake.
- `req_ready`=0 in every non-IDLE state. At most one outstanding request. Back-to-back requests issue every 4 cycles (2 for errors).
- Request inputs may change freely after the handshake; only latched copies are used.
- Reset mid-operation returns to IDLE immediately and no response is produced. A store reset after WRITE may still commit in the RAM; this is acceptable.
- `resp_rdata`/`resp_err` hold their last values outside RESP until the next response; they are qualified only by `resp_valid`.

## Structure
- Shared package: size encodings (`kSizeByte`/`kSizeHalf`/`kSizeWord`), state encoding, lane count constant.
- Sub-module `ram_lane_align` (combinational): from size/offset/signed produces write-select and steered write data, and extracts/extends read data.
- FSM, request latch and response register stay in `ram_master`.

## Test plan
- Store word 0x11223344 @0x10, then load word @0x10 → write_sel 1111 in WRITE and WHOLD; `resp_rdata`=0x11223344, 3-cycle latency each.
- Store byte 0xAB @0x21, then signed byte load @0x21 → sel 0010, ram_wdata 0xABABABAB; `resp_rdata`=0xFFFFFFAB. Unsigned load → 0x000000AB.
- Store half 0x8001 @0x32, then signed half load @0x32 → sel 1100; `resp_rdata`=0xFFFF8001. Half @0x30 still reads its prior value.
- Word load @0x13 and half store @0x05 → `resp_err`=1 one cycle after the handshake; `ram_en` never asserted.
- Reset asserted during RDATA → all outputs 0 and no `resp_valid`. After release, a fresh load completes normally.
- Random back-to-back requests with `req_valid` held high → `req_ready` only in IDLE; responses in order; contents match a byte-array reference model.

Source files
------------

// File: rtl/ram_master_pkg.sv
// ram_master_pkg
// Shared definitions for the RAM initiator: bus widths, access-size
// encodings, FSM state encoding and the alignment rule used at handshake.
package ram_master_pkg;

   localparam int kAddrWidth = 32;
   localparam int kDataWidth = 32;
   localparam int kNumLanes  = 4;

   localparam logic [1:0] kSizeByte = 2'd0;
   localparam logic [1:0] kSizeHalf = 2'd1;
   localparam logic [1:0] kSizeWord = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      RDATA,
      WRITE,
      WHOLD,
      RESP
   } state_e;

   // Reserved size (3) is treated as an alignment error so it never
   // reaches the RAM.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      case (size)
         kSizeByte: return 1'b0;
         kSizeHalf: return offset[0];
         kSizeWord: return (offset != 2'b00);
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/ram_master_if.sv
// ram_master_if
// Bundles the pipeline request/response handshake and the RAM port.
//   master modport : the initiator (drives req_ready, resp_*, ram_* outputs)
//   slave modport  : the environment (pipeline stage plus RAM)
// Signals:
//   req_valid/req_ready   request handshake
//   req_write/req_size/req_signed/req_addr/req_wdata   request fields
//   resp_valid/resp_err/resp_rdata   one-cycle response
//   ram_en/ram_write_sel/ram_addr/ram_wdata/ram_rdata   RAM port
interface ram_master_if;
   import ram_master_pkg::*;

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [1:0]              req_size;
   logic                    req_signed;
   logic [kAddrWidth-1:0]   req_addr;
   logic [kDataWidth-1:0]   req_wdata;

   logic                    resp_valid;
   logic                    resp_err;
   logic [kDataWidth-1:0]   resp_rdata;

   logic                    ram_en;
   logic [kNumLanes-1:0]    ram_write_sel;
   logic [kAddrWidth-1:0]   ram_addr;
   logic [kDataWidth-1:0]   ram_wdata;
   logic [kDataWidth-1:0]   ram_rdata;

   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  ram_rdata,
      output req_ready,
      output resp_valid, resp_err, resp_rdata,
      output ram_en, ram_write_sel, ram_addr, ram_wdata
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output ram_rdata,
      input  req_ready,
      input  resp_valid, resp_err, resp_rdata,
      input  ram_en, ram_write_sel, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_lane_align.sv
// ram_lane_align
// Combinational byte-lane helper for the RAM initiator.
//   size/offset/is_signed : access descriptor (offset = byte address [1:0])
//   wdata       -> wdata_lanes, write_sel : store data replicated across lanes
//                                           plus the lane enables it touches
//   rdata       -> rdata_ext              : load data shifted down to bit 0
//                                           and zero/sign extended
module ram_lane_align
   import ram_master_pkg::*;
(
   input  logic [1:0]             size,
   input  logic [1:0]             offset,
   input  logic                   is_signed,
   input  logic [kDataWidth-1:0]  wdata,
   input  logic [kDataWidth-1:0]  rdata,
   output logic [kNumLanes-1:0]   write_sel,
   output logic [kDataWidth-1:0]  wdata_lanes,
   output logic [kDataWidth-1:0]  rdata_ext
);

   logic [kDataWidth-1:0] rdata_shift;

   // Replicating the store data means every lane already carries the right
   // byte; write_sel alone picks which lanes the RAM commits.
   always_comb begin
      write_sel   = '0;
      wdata_lanes = '0;
      case (size)
         kSizeByte: begin
            write_sel   = 4'b0001 << offset;
            wdata_lanes = {4{wdata[7:0]}};
         end
         kSizeHalf: begin
            write_sel   = offset[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
         end
         kSizeWord: begin
            write_sel   = 4'b1111;
            wdata_lanes = wdata;
         end
         default: ;
      endcase
   end

   // Loads bring the addressed byte/half down to bit 0 before extension.
   always_comb begin
      rdata_shift = rdata >> {offset, 3'b000};
      rdata_ext   = rdata_shift;
      case (size)
         kSizeByte: rdata_ext = {{24{is_signed & rdata_shift[7]}}, rdata_shift[7:0]};
         kSizeHalf: rdata_ext = {{16{is_signed & rdata_shift[15]}}, rdata_shift[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/ram_master.sv
// ram_master
// Initiator for the word-addressed on-chip RAM. Takes one byte/half/word
// load or store at a time, checks alignment, steers byte lanes, sequences
// the RAM's two-cycle write and one-cycle-latency read, and returns a
// one-cycle response.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : ram_master_if.master (request, response and RAM port)
module ram_master
   import ram_master_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   ram_master_if.master  bus
);

   state_e                 state;

   logic [1:0]             lat_size;
   logic [1:0]             lat_offset;
   logic                   lat_signed;

   logic                   resp_valid_q;
   logic                   resp_err_q;
   logic [kDataWidth-1:0]  resp_rdata_q;

   logic                   ram_en_q;
   logic [kNumLanes-1:0]   ram_sel_q;
   logic [kAddrWidth-1:0]  ram_addr_q;
   logic [kDataWidth-1:0]  ram_wdata_q;

   logic                   in_idle;
   logic [1:0]             al_size;
   logic [1:0]             al_offset;
   logic                   al_signed;
   logic [kNumLanes-1:0]   al_sel;
   logic [kDataWidth-1:0]  al_wdata;
   logic [kDataWidth-1:0]  al_rdata;

   assign in_idle = (state == IDLE);

   // In IDLE the lane helper looks at the live request so the RAM outputs
   // can be registered on the handshake edge; afterwards it sees the
   // latched copy, which is what the load extraction in RDATA needs.
   assign al_size   = in_idle ? bus.req_size       : lat_size;
   assign al_offset = in_idle ? bus.req_addr[1:0]  : lat_offset;
   assign al_signed = in_idle ? bus.req_signed     : lat_signed;

   ram_lane_align u_align (
      .size        (al_size),
      .offset      (al_offset),
      .is_signed   (al_signed),
      .wdata       (bus.req_wdata),
      .rdata       (bus.ram_rdata),
      .write_sel   (al_sel),
      .wdata_lanes (al_wdata),
      .rdata_ext   (al_rdata)
   );

   // Ready is gated by reset so nothing is accepted while reset is held.
   assign bus.req_ready     = in_idle & rst;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_err      = resp_err_q;
   assign bus.resp_rdata    = resp_rdata_q;
   assign bus.ram_en        = ram_en_q;
   assign bus.ram_write_sel = ram_sel_q;
   assign bus.ram_addr      = ram_addr_q;
   assign bus.ram_wdata     = ram_wdata_q;

   // Main sequencer. All outputs are registered and set up on the edge that
   // enters the state they belong to. resp_rdata/resp_err are only
   // rewritten when a new response is produced.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         lat_size     <= '0;
         lat_offset   <= '0;
         lat_signed   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         ram_en_q     <= 1'b0;
         ram_sel_q    <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_size   <= bus.req_size;
                  lat_offset <= bus.req_addr[1:0];
                  lat_signed <= bus.req_signed;
                  if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                     state        <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     ram_en_q   <= 1'b1;
                     ram_addr_q <= {bus.req_addr[kAddrWidth-1:2], 2'b00};
                     if (bus.req_write) begin
                        state       <= WRITE;
                        ram_sel_q   <= al_sel;
                        ram_wdata_q <= al_wdata;
                     end else begin
                        state       <= READ;
                        ram_sel_q   <= '0;
                        ram_wdata_q <= '0;
                     end
                  end
               end
            end
            READ: begin
               state      <= RDATA;
               ram_en_q   <= 1'b0;
               ram_addr_q <= '0;
            end
            RDATA: begin
               state        <= RESP;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= al_rdata;
            end
            WRITE: begin
               // The RAM commits on its delayed enable, so the lane enables,
               // address and data must stay put for one more cycle.
               state    <= WHOLD;
               ram_en_q <= 1'b0;
            end
            WHOLD: begin
               state        <= RESP;
               ram_sel_q    <= '0;
               ram_addr_q   <= '0;
               ram_wdata_q  <= '0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
            end
            RESP: begin
               state        <= IDLE;
               resp_valid_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master
// Self-checking bench for ram_master. Contains a behavioural RAM (registered
// read, store committed on the delayed enable) and a byte-array reference
// model that predicts every output on every cycle from the access rules.
module tb_ram_master;
   import ram_master_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ram_master_if bus ();

   ram_master dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural RAM ----------------
   logic [7:0]  ram_mem [0:255];
   logic [31:0] ram_rdata_r = '0;
   logic        wr_pend = 1'b0;

   assign bus.ram_rdata = ram_rdata_r;

   always @(posedge clk) begin
      if (wr_pend && bus.ram_addr < 32'd256) begin
         for (int k = 0; k < 4; k++)
            if (bus.ram_write_sel[k])
               ram_mem[bus.ram_addr + k] = bus.ram_wdata[8*k +: 8];
      end
      wr_pend <= bus.ram_en && (bus.ram_write_sel != 4'b0000);
      if (bus.ram_en && bus.ram_write_sel == 4'b0000) begin
         if (bus.ram_addr < 32'd256)
            ram_rdata_r <= {ram_mem[bus.ram_addr + 3], ram_mem[bus.ram_addr + 2],
                            ram_mem[bus.ram_addr + 1], ram_mem[bus.ram_addr]};
         else
            ram_rdata_r <= '0;
      end
   end

   // ---------------- reference model state ----------------
   logic [7:0]  ref_mem [0:255];
   logic        pending = 1'b0;
   int          t_start = 0;
   logic        t_write, t_err;
   logic [31:0] t_base, t_wlanes, t_rdata;
   logic [3:0]  t_sel;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   // observations used by the directed literal checks
   int          resp_count = 0;
   int          en_count   = 0;
   int          obs_lat    = 0;
   logic [31:0] obs_rdata  = '0;
   logic        obs_err    = 1'b0;
   logic [3:0]  obs_sel    = '0;
   logic [31:0] obs_wdata  = '0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // Predict a transaction from its request fields at handshake time.
   task automatic model_accept(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] d);
      int nb;
      logic [31:0] val;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      t_write  = w;
      t_err    = (nb == 0) || ((a % nb) != 0);
      t_base   = a & 32'hFFFF_FFFC;
      t_sel    = '0;
      t_wlanes = '0;
      t_rdata  = '0;
      if (!t_err) begin
         if (w) begin
            for (int k = 0; k < 4; k++) begin
               t_wlanes[8*k +: 8] = d[8*(k % nb) +: 8];
               if (t_base + k >= a && t_base + k < a + nb) begin
                  t_sel[k] = 1'b1;
                  ref_mem[t_base + k] = d[8*(k - (a - t_base)) +: 8];
               end
            end
         end else begin
            val = '0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[a + i];
            if (sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
            t_rdata = val;
         end
      end
      pending = 1'b1;
   endtask

   // One compare process: every cycle, sampled on the falling edge.
   always @(negedge clk) begin : compare_proc
      logic        e_ready, e_en, e_valid, e_err;
      logic [3:0]  e_sel;
      logic [31:0] e_addr, e_wdata, e_rdata;
      int          p;
      e_ready = 1'b0; e_en = 1'b0; e_valid = 1'b0;
      e_sel = '0; e_addr = '0; e_wdata = '0;
      e_err = last_err; e_rdata = last_rdata;
      if (!rst) begin
         pending    = 1'b0;
         last_rdata = '0;
         last_err   = 1'b0;
         e_err      = 1'b0;
         e_rdata    = '0;
      end else begin
         e_ready = !pending;
         if (pending) begin
            p = cyc - t_start;
            if (t_err) begin
               if (p == 0) begin e_valid = 1'b1; e_err = 1'b1; e_rdata = '0; end
            end else begin
               if (p == 0 || (p == 1 && t_write)) begin
                  e_en   = (p == 0);
                  e_addr = t_base;
                  if (t_write) begin e_sel = t_sel; e_wdata = t_wlanes; end
               end
               if (p == 2) begin e_valid = 1'b1; e_err = 1'b0; e_rdata = t_rdata; end
            end
         end
      end
      check_output("req_ready",     {31'd0, bus.req_ready},  {31'd0, e_ready});
      check_output("resp_valid",    {31'd0, bus.resp_valid}, {31'd0, e_valid});
      check_output("resp_err",      {31'd0, bus.resp_err},   {31'd0, e_err});
      check_output("resp_rdata",    bus.resp_rdata,          e_rdata);
      check_output("ram_en",        {31'd0, bus.ram_en},     {31'd0, e_en});
      check_output("ram_write_sel", {28'd0, bus.ram_write_sel}, {28'd0, e_sel});
      check_output("ram_addr",      bus.ram_addr,            e_addr);
      check_output("ram_wdata",     bus.ram_wdata,           e_wdata);

      if (bus.ram_en) en_count++;
      if (bus.ram_en && bus.ram_write_sel != 4'b0000) begin
         obs_sel   = bus.ram_write_sel;
         obs_wdata = bus.ram_wdata;
      end
      if (bus.resp_valid) begin
         resp_count++;
         obs_rdata = bus.resp_rdata;
         obs_err   = bus.resp_err;
         obs_lat   = cyc - t_start + 1;
      end
      if (e_valid) begin
         pending    = 1'b0;
         last_rdata = e_rdata;
         last_err   = e_err;
      end
      if (rst && !pending && bus.req_valid && bus.req_ready) begin
         model_accept(bus.req_write, bus.req_size, bus.req_signed, bus.req_addr, bus.req_wdata);
         t_start = cyc + 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic hold);
      int   n;
      logic got;
      n = 0;
      got = 1'b0;
      bus.req_write  = w;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_valid  = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         if (bus.req_ready && rst) got = 1'b1;
         n++;
      end
      if (!got) begin
         check_output("ready_timeout", 32'd0, 32'd1);
         bus.req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
      end
      if (!hold) begin
         bus.req_valid  = 1'b0;
         bus.req_write  = 1'($urandom);
         bus.req_size   = 2'($urandom);
         bus.req_signed = 1'($urandom);
         bus.req_addr   = $urandom;
         bus.req_wdata  = $urandom;
      end
   endtask

   task automatic wait_response(input int start);
      int n;
      n = 0;
      while (resp_count == start && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (resp_count == start) check_output("resp_timeout", 32'd0, 32'd1);
   endtask

   // Directed transaction with hand-computed expectations.
   task automatic do_txn(input string name, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int start;
      start = resp_count;
      apply_stimulus(w, sz, sg, a, d, 1'b0);
      wait_response(start);
      check_output({name, "_rdata"}, obs_rdata, exp_rdata);
      check_output({name, "_err"}, {31'd0, obs_err}, {31'd0, exp_err});
      check_output({name, "_lat"}, obs_lat, exp_lat);
   endtask

   initial begin
      int          en_before;
      int          resp_before;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      $display("[TB] directed word/byte/half accesses");
      do_txn("st_word", 1'b1, kSizeWord, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 3);
      check_output("st_word_sel", {28'd0, obs_sel}, 32'h0000000F);
      do_txn("ld_word", 1'b0, kSizeWord, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 3);

      do_txn("st_byte", 1'b1, kSizeByte, 1'b0, 32'h21, 32'h123456AB, 32'h0, 1'b0, 3);
      check_output("st_byte_sel", {28'd0, obs_sel}, 32'h00000002);
      check_output("st_byte_wdata", obs_wdata, 32'hABABABAB);
      do_txn("ld_sbyte", 1'b0, kSizeByte, 1'b1, 32'h21, 32'h0, 32'hFFFFFFAB, 1'b0, 3);
      do_txn("ld_ubyte", 1'b0, kSizeByte, 1'b0, 32'h21, 32'h0, 32'h000000AB, 1'b0, 3);
      do_txn("ld_word20", 1'b0, kSizeWord, 1'b0, 32'h20, 32'h0, 32'h0000AB00, 1'b0, 3);

      do_txn("st_half", 1'b1, kSizeHalf, 1'b0, 32'h32, 32'hDEAD8001, 32'h0, 1'b0, 3);
      check_output("st_half_sel", {28'd0, obs_sel}, 32'h0000000C);
      check_output("st_half_wdata", obs_wdata, 32'h80018001);
      do_txn("ld_shalf", 1'b0, kSizeHalf, 1'b1, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, 3);
      do_txn("ld_half30", 1'b0, kSizeHalf, 1'b1, 32'h30, 32'h0, 32'h00000000, 1'b0, 3);

      $display("[TB] misaligned and reserved requests");
      en_before = en_count;
      do_txn("err_word", 1'b0, kSizeWord, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
      do_txn("err_half", 1'b1, kSizeHalf, 1'b0, 32'h05, 32'hFFFF, 32'h0, 1'b1, 1);
      do_txn("err_rsvd", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1);
      check_output("err_no_ram_en", en_count, en_before);

      $display("[TB] reset during RDATA");
      resp_before = resp_count;
      apply_stimulus(1'b0, kSizeWord, 1'b0, 32'h10, 32'h0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      check_output("reset_no_resp", resp_count, resp_before);
      do_txn("ld_after_rst", 1'b0, kSizeWord, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 3);

      $display("[TB] random back-to-back requests");
      resp_before = resp_count;
      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? kSizeByte : (r < 6) ? kSizeHalf : (r < 9) ? kSizeWord : 2'd3;
         a  = {24'd0, 8'($urandom)};
         if ($urandom_range(0, 9) < 8) begin
            if (sz == kSizeHalf) a[0] = 1'b0;
            if (sz == kSizeWord) a[1:0] = 2'b00;
         end
         apply_stimulus(1'($urandom), sz, 1'($urandom), a, $urandom, (i != 299));
      end
      wait_response(resp_before + 299);
      check_output("rand_resp_count", resp_count, resp_before + 300);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
